// File: rtl/samp_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : samp_seq_gen                                                 |
// | Description : ADC sampling-sequence generator. Frames each sample strobe   |
// |               with setup/hold guard intervals on the p/n enables, then     |
// |               issues a one-cycle conversion start and waits for done.      |
// |               Single-shot and continuous modes.                            |
// |               Optional CONVERT timeout: define SAMP_SEQ_TIMEOUT_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module samp_seq_gen #(
    parameter int SW    = 8,
    parameter int GUARD = 2,
    parameter int CW    = 16
`ifdef SAMP_SEQ_TIMEOUT_EN
    ,
    parameter int TO_CYC = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic [SW-1:0] samp_len,
    input  logic          p_mask,
    input  logic          n_mask,
    input  logic          conv_done,
    output logic          seq_samp,
    output logic          samp_p_en,
    output logic          samp_n_en,
    output logic          conv_start,
    output logic          busy,
    output logic [CW-1:0] frame_cnt
`ifdef SAMP_SEQ_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    // Phase counter must hold both the guard length and the sample length.
    localparam int C_GUARD_W = $clog2(GUARD + 1);
    localparam int C_CNT_W   = (SW > C_GUARD_W) ? SW : C_GUARD_W;
    localparam logic [C_CNT_W-1:0] C_GUARD_LAST = C_CNT_W'(GUARD - 1);

`ifdef SAMP_SEQ_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TO_CYC + 1);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TO_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_CONVERT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]       len_q, len_d;
    logic                p_lat_q, p_lat_d;
    logic                n_lat_q, n_lat_d;
    logic [CW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                seq_samp_q, seq_samp_d;
    logic                p_en_q, p_en_d;
    logic                n_en_q, n_en_d;
    logic                conv_start_q, conv_start_d;
    logic                busy_q, busy_d;
    logic                latch;
    logic                enables_on;
    logic [C_CNT_W-1:0]  samp_last;
`ifdef SAMP_SEQ_TIMEOUT_EN
    logic [C_TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic                timeout_q, timeout_d;
`endif

    // Latched length is never 0, so L-1 cannot underflow.
    assign samp_last = C_CNT_W'(len_q) - C_CNT_W'(1);

    // Next-state, frame latching and registered-output precompute.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        p_lat_d     = p_lat_q;
        n_lat_d     = n_lat_q;
        frame_cnt_d = frame_cnt_q;
        latch       = 1'b0;
`ifdef SAMP_SEQ_TIMEOUT_EN
        to_cnt_d    = '0;
        timeout_d   = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && (p_mask || n_mask)) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    latch   = 1'b1;
`ifdef SAMP_SEQ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_q == C_GUARD_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == samp_last) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == C_GUARD_LAST) begin
                    state_d = ST_CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    frame_cnt_d = frame_cnt_q + CW'(1);
                    cnt_d       = '0;
                    if (cont && (p_mask || n_mask)) begin
                        state_d = ST_SETUP;
                        latch   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef SAMP_SEQ_TIMEOUT_EN
                else if (to_cnt_q == C_TO_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + C_TO_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (latch) begin
            len_d   = (samp_len == '0) ? SW'(1) : samp_len;
            p_lat_d = p_mask;
            n_lat_d = n_mask;
        end

        // Abort overrides everything, including a same-cycle done accept.
        if (abort) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            frame_cnt_d = frame_cnt_q;
`ifdef SAMP_SEQ_TIMEOUT_EN
            to_cnt_d    = '0;
            timeout_d   = timeout_q;
`endif
        end

        // Outputs are decoded from the next state so they come straight off flops.
        enables_on   = (state_d == ST_SETUP) || (state_d == ST_SAMPLE) ||
                       (state_d == ST_RELEASE);
        p_en_d       = enables_on && p_lat_d;
        n_en_d       = enables_on && n_lat_d;
        seq_samp_d   = (state_d == ST_SAMPLE);
        conv_start_d = (state_d == ST_CONVERT) && (state_q != ST_CONVERT);
        busy_d       = (state_d != ST_IDLE);
    end

    // State, frame context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= SW'(1);
            p_lat_q      <= 1'b0;
            n_lat_q      <= 1'b0;
            frame_cnt_q  <= '0;
            seq_samp_q   <= 1'b0;
            p_en_q       <= 1'b0;
            n_en_q       <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            p_lat_q      <= p_lat_d;
            n_lat_q      <= n_lat_d;
            frame_cnt_q  <= frame_cnt_d;
            seq_samp_q   <= seq_samp_d;
            p_en_q       <= p_en_d;
            n_en_q       <= n_en_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SAMP_SEQ_TIMEOUT_EN
    // CONVERT wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign seq_samp   = seq_samp_q;
    assign samp_p_en  = p_en_q;
    assign samp_n_en  = n_en_q;
    assign conv_start = conv_start_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_samp_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_samp_seq_gen                                              |
// | Description : Self-checking bench for samp_seq_gen: frame-level scoreboard |
// |               plus directed boundary scenarios.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_samp_seq_gen;

    localparam int G      = 2;
    localparam int SW     = 8;
    localparam int CW     = 6;
    localparam int TO_CYC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] samp_len = '0;
    logic          p_mask = 1'b0;
    logic          n_mask = 1'b0;
    logic          conv_done = 1'b0;
    logic          seq_samp, samp_p_en, samp_n_en, conv_start, busy;
    logic [CW-1:0] frame_cnt;
`ifdef SAMP_SEQ_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    samp_seq_gen #(
        .SW(SW), .GUARD(G), .CW(CW)
`ifdef SAMP_SEQ_TIMEOUT_EN
        , .TO_CYC(TO_CYC)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .samp_len(samp_len), .p_mask(p_mask), .n_mask(n_mask),
        .conv_done(conv_done), .seq_samp(seq_samp), .samp_p_en(samp_p_en),
        .samp_n_en(samp_n_en), .conv_start(conv_start), .busy(busy),
        .frame_cnt(frame_cnt)
`ifdef SAMP_SEQ_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    typedef struct {
        bit p;
        bit n;
        int len;
    } frame_t;

    frame_t exp_q[$];
    frame_t mf;
    int     n_checks = 0;
    int     n_errors = 0;
    int     exp_fc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: rebuild each frame from the enable/strobe waveform.
    int run = 0, samp_off = -1, samp_cnt = 0;
    bit run_p = 0, run_n = 0, stable = 1, prev_en = 0, prev_cs = 0;

    always @(negedge clk) begin
        bit en;
        en = samp_p_en | samp_n_en;
        if (!rst_n) begin
            prev_en = 0;
            prev_cs = 0;
            run     = 0;
        end else begin
            if (en && !prev_en) begin
                run = 0; samp_off = -1; samp_cnt = 0;
                run_p = samp_p_en; run_n = samp_n_en; stable = 1;
            end
            if (en) begin
                if (samp_p_en != run_p || samp_n_en != run_n) stable = 0;
                if (seq_samp) begin
                    if (samp_cnt == 0) samp_off = run;
                    samp_cnt++;
                end
                run++;
            end
            if (seq_samp) chk("samp_gate", en, 1);
            if (conv_start) begin
                chk("cs_single", prev_cs, 0);
                chk("cs_en_low", en, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL cs_unexpected: got conv_start, expected none (t=%0t)", $time);
                end else begin
                    mf = exp_q.pop_front();
                    chk("en_len", run, 2 * G + mf.len);
                    chk("samp_off", samp_off, G);
                    chk("samp_width", samp_cnt, mf.len);
                    chk("p_en_val", run_p, mf.p);
                    chk("n_en_val", run_n, mf.n);
                    chk("en_stable", stable, 1);
                    chk("cs_follows_en", prev_en, 1);
                end
            end
            prev_en = en;
            prev_cs = conv_start;
        end
    end

    function automatic logic [SW-1:0] rand_len();
        if ($urandom_range(0, 7) == 0) return '0;
        return SW'($urandom_range(1, 9));
    endfunction

    task automatic pick_masks(output bit p, output bit n);
        int r;
        r = $urandom_range(1, 3);
        p = r[0];
        n = r[1];
    endtask

    task automatic scramble_inputs();
        samp_len = SW'($urandom_range(0, 255));
        p_mask   = 1'($urandom_range(0, 1));
        n_mask   = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_start(input bit p, input bit n, input logic [SW-1:0] len);
        @(negedge clk);
        start = 1; p_mask = p; n_mask = n; samp_len = len;
        exp_q.push_back('{p, n, (len == '0) ? 1 : int'(len)});
        @(negedge clk);
        start = 0;
        chk("busy_rise", busy, 1);
        chk("p_en_rise", samp_p_en, p);
        chk("n_en_rise", samp_n_en, n);
        chk("samp_low_setup", seq_samp, 0);
        scramble_inputs();
    endtask

    task automatic wait_cs(output bit ok);
        ok = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (conv_start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL cs_timeout: got no conv_start, expected one within 700 cycles");
        end
    endtask

    // Called on the negedge where conv_start is visible.
    task automatic finish_frame(input int dly, input bit nc, input bit np,
                                input bit nn, input logic [SW-1:0] nlen);
        bit go;
        repeat (dly) @(negedge clk);
        conv_done = 1; cont = nc; p_mask = np; n_mask = nn; samp_len = nlen;
        go = nc && (np || nn);
        if (go) exp_q.push_back('{np, nn, (nlen == '0) ? 1 : int'(nlen)});
        @(negedge clk);
        conv_done = 0; cont = 0;
        exp_fc = (exp_fc + 1) % (1 << CW);
        chk("frame_cnt", frame_cnt, exp_fc);
        chk("busy_after_done", busy, go);
        if (go) begin
            chk("cont_p_en", samp_p_en, np);
            chk("cont_n_en", samp_n_en, nn);
        end
        scramble_inputs();
    endtask

    task automatic rand_frames(input int nf);
        bit ok, p, n;
        logic [SW-1:0] l;
        pick_masks(p, n);
        issue_start(p, n, rand_len());
        for (int i = 0; i < nf; i++) begin
            wait_cs(ok);
            if (!ok) return;
            pick_masks(p, n);
            l = rand_len();
            finish_frame($urandom_range(0, 3), i < nf - 1, p, n, l);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_samp"}, seq_samp, 0);
        chk({tag, "_p_en"}, samp_p_en, 0);
        chk({tag, "_n_en"}, samp_n_en, 0);
        chk({tag, "_cs"}, conv_start, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit ok;
        // Reset state.
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_fc", frame_cnt, 0);
        rst_n = 1;

        // Single shot, both sides, L=4, done three cycles after conv_start;
        // stray conv_done and start during SETUP are ignored.
        issue_start(1, 1, 4);
        conv_done = 1; start = 1;
        @(negedge clk);
        conv_done = 0; start = 0;
        chk("done_outside_convert", frame_cnt, exp_fc);
        wait_cs(ok);
        if (ok) finish_frame(3, 0, 0, 0, 0);
        @(negedge clk);
        check_idle_outputs("after_single");

        // samp_len=0 with p only, done in the same cycle as conv_start.
        issue_start(1, 0, 0);
        wait_cs(ok);
        if (ok) finish_frame(0, 0, 0, 0, 0);

        // start with both masks clear is ignored; so is start under abort.
        @(negedge clk);
        start = 1; p_mask = 0; n_mask = 0; samp_len = 5;
        repeat (2) @(negedge clk);
        chk("nomask_busy", busy, 0);
        p_mask = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("abort_start_busy", busy, 0);

        // Continuous mode, three frames.
        rand_frames(3);
        chk("cont_fc", frame_cnt, exp_fc);

        // Maximum sample length.
        issue_start(0, 1, 255);
        wait_cs(ok);
        if (ok) finish_frame(1, 0, 0, 0, 0);

        // Abort during SAMPLE.
        issue_start(1, 1, 6);
        for (int i = 0; i < 20 && !seq_samp; i++) @(negedge clk);
        chk("reached_sample", seq_samp, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check_idle_outputs("abort_sample");
        chk("abort_sample_fc", frame_cnt, exp_fc);
        exp_q.delete();

        // Abort in CONVERT with conv_done high: no increment.
        issue_start(0, 1, 2);
        wait_cs(ok);
        conv_done = 1; abort = 1;
        @(negedge clk);
        conv_done = 0; abort = 0;
        check_idle_outputs("abort_convert");
        chk("abort_convert_fc", frame_cnt, exp_fc);

        // Randomized continuous run long enough to wrap frame_cnt.
        rand_frames((1 << CW) + 3);
        rand_frames(5);

        // Reset asserted mid-CONVERT clears immediately.
        issue_start(1, 1, 3);
        wait_cs(ok);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check_idle_outputs("async_reset");
        chk("async_reset_fc", frame_cnt, 0);
        exp_fc = 0;
        conv_done = 0;
        @(negedge clk);
        #2 rst_n = 1;

`ifdef SAMP_SEQ_TIMEOUT_EN
        // No conv_done: timeout after TO_CYC CONVERT cycles, cleared by next start.
        issue_start(1, 0, 2);
        wait_cs(ok);
        chk("to_clear_initial", timeout, 0);
        repeat (TO_CYC - 1) @(negedge clk);
        chk("to_busy_last", busy, 1);
        chk("to_not_yet", timeout, 0);
        @(negedge clk);
        chk("to_busy_fall", busy, 0);
        chk("to_set", timeout, 1);
        chk("to_fc", frame_cnt, exp_fc);
        issue_start(1, 1, 1);
        chk("to_cleared", timeout, 0);
        wait_cs(ok);
        if (ok) finish_frame(2, 0, 0, 0, 0);
`endif

        rand_frames(4);
        repeat (3) @(negedge clk);
        check_idle_outputs("final");
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
